// File: rtl/mem_lsu.sv
// Load/store unit between a CPU request/response port and a single-cycle,
// word-addressed memory. Byte and halfword stores use read-modify-write.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds its payload until that edge.
module mem_lsu #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] cap_word;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merge_word;
    logic        accept;
    logic        do_load;
    logic        do_capture;

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state;

    // Classify an incoming request: reserved size, misalignment, out of range.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = |req_addr[1:0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
        if (req_addr[31:2] >= 30'(MEM_WORDS)) req_bad = 1'b1;
    end

    // Pick the addressed lane out of the memory word and extend it.
    always_comb begin
        byte_sel = mem_rd[7:0];
        case (lat_addr[1:0])
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            2'd3:    byte_sel = mem_rd[31:24];
            default: byte_sel = mem_rd[7:0];
        endcase
        half_sel = lat_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (lat_size)
            2'b00:   load_val = {{24{lat_signed & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{lat_signed & half_sel[15]}}, half_sel};
            default: load_val = mem_rd;
        endcase
    end

    // Replace only the addressed byte/half lane of the captured word.
    always_comb begin
        merge_word = cap_word;
        if (lat_size == 2'b00) begin
            case (lat_addr[1:0])
                2'd0:    merge_word[7:0]   = lat_wdata[7:0];
                2'd1:    merge_word[15:8]  = lat_wdata[7:0];
                2'd2:    merge_word[23:16] = lat_wdata[7:0];
                default: merge_word[31:24] = lat_wdata[7:0];
            endcase
        end else if (lat_addr[1]) begin
            merge_word[31:16] = lat_wdata[15:0];
        end else begin
            merge_word[15:0] = lat_wdata[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and per-state outputs; memory strobes decode from state only.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_a      = 32'h0;
        mem_wd     = 32'h0;
        accept     = 1'b0;
        do_load    = 1'b0;
        do_capture = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_a = {lat_addr[31:2], 2'b00};
                if (!lat_we) begin
                    do_load  = 1'b1;
                    state_nx = RESP;
                end else if (lat_size == 2'b10) begin
                    mem_we   = 1'b1;
                    mem_wd   = lat_wdata;
                    state_nx = RESP;
                end else begin
                    do_capture = 1'b1;
                    state_nx   = WRITE;
                end
            end
            WRITE: begin
                mem_a    = {lat_addr[31:2], 2'b00};
                mem_we   = 1'b1;
                mem_wd   = merge_word;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request fields, captured memory word and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            cap_word   <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                lat_we     <= req_we;
                lat_size   <= req_size;
                lat_signed <= req_signed;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                rdata_q    <= 32'h0;
                err_q      <= req_bad;
            end
            if (do_load)    rdata_q  <= load_val;
            if (do_capture) cap_word <= mem_rd;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomised checks of mem_lsu against a bench-owned memory
// and a queue of expected responses.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:63];
    logic        tb_we = 1'b0;
    logic [5:0]  tb_idx = 6'd0;
    logic [31:0] tb_data = 32'h0;
    int          we_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] err_q[$];
    logic [31:0] lat_q[$];
    int          total = 0;
    int          bad = 0;

    mem_lsu #(.MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .dbg_state(dbg_state)
    );

    // Clock and memory model.
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
            we_cnt <= we_cnt + 1;
        end else if (tb_we) begin
            mem[tb_idx] <= tb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        tb_we = 1'b1;
        tb_idx = idx[5:0];
        tb_data = data;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * lane));
        h = 16'(w >> (16 * lane[1]));
        if (size == 2'b00) return sgn ? {{24{b[7]}}, b} : {24'h0, b};
        if (size == 2'b01) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
        return w;
    endfunction

    // Issue one request, then match the response against the queue heads.
    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_we, input int hold);
        int          lat;
        int          we_base;
        logic [31:0] e_rd, e_err, e_lat;
        exp_q.push_back(exp_rd);
        err_q.push_back({31'h0, exp_err});
        lat_q.push_back(32'(exp_lat));
        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'd1);
        we_base    = we_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = 32'h0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e_rd  = exp_q.pop_front();
        e_err = err_q.pop_front();
        e_lat = lat_q.pop_front();
        check("resp_valid_seen", {31'h0, resp_valid}, 32'd1);
        check("latency", 32'(lat), e_lat);
        check("rdata", resp_rdata, e_rd);
        check("err", {31'h0, resp_err}, e_err);
        check("req_ready_in_resp", {31'h0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'h0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, e_rd);
            check("hold_err", {31'h0, resp_err}, e_err);
            check("hold_req_ready", {31'h0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("resp_valid_drop", {31'h0, resp_valid}, 32'd0);
        check("req_ready_back", {31'h0, req_ready}, 32'd1);
        check("mem_we_cycles", 32'(we_cnt - we_base), 32'(exp_we));
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sg;
        int          idx;

        // Reset held while the memory image is loaded.
        for (int i = 0; i < 64; i++) poke(i, 32'h5A00_0000 + 32'(i));
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'h0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'd0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'd0);
        poke(1, 32'h1122_3344);
        poke(2, 32'hAABB_CC80);
        poke(3, 32'h1122_3344);
        poke(6, 32'hCAFE_F00D);
        for (int i = 8; i < 16; i++) poke(i, $urandom);
        @(negedge clk);
        reset = 1'b1;

        // Directed loads.
        send(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'h0000_0011, 1'b0, 2, 0, 0);
        send(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h0000_1122, 1'b0, 2, 0, 0);
        send(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 0);
        send(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 0);
        send(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'hFFFF_AABB, 1'b0, 2, 0, 0);
        send(1'b0, 2'b10, 1'b1, 32'h8, 32'h0, 32'hAABB_CC80, 1'b0, 2, 0, 0);

        // Randomised byte/half loads from words 8..15.
        for (int n = 0; n < 8; n++) begin
            idx = $urandom_range(8, 15);
            sz  = 2'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            a   = 32'(idx * 4) + ((sz == 2'b00) ? 32'($urandom_range(0, 3))
                                                : 32'(2 * $urandom_range(0, 1)));
            w   = mem[idx];
            send(1'b0, sz, sg, a, 32'h0, model_load(w, a[1:0], sz, sg), 1'b0, 2, 0, 0);
        end

        // Byte store via read-modify-write.
        send(1'b1, 2'b00, 1'b0, 32'hD, 32'h0000_00EE, 32'h0, 1'b0, 3, 1, 0);
        check("mem3_byte_store", mem[3], 32'h1122_EE44);

        // Rejected requests: no memory write, one-cycle error response.
        send(1'b1, 2'b10, 1'b0, 32'h3, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0, 0);
        check("mem0_after_misaligned", mem[0], 32'h5A00_0000);
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0, 0);
        check("mem0_after_oob", mem[0], 32'h5A00_0000);
        send(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        send(1'b1, 2'b01, 1'b0, 32'h5, 32'h1234, 32'h0, 1'b1, 1, 0, 0);
        check("mem1_after_bad_half", mem[1], 32'h1122_3344);

        // Word and halfword stores.
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 0);
        check("mem4_word_store", mem[4], 32'hDEAD_BEEF);
        send(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_5566, 32'h0, 1'b0, 3, 1, 0);
        check("mem5_half_store", mem[5], 32'h5566_0005 | 32'h5A00_0000 & 32'h0000_FFFF);

        // Response back-pressure.
        send(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 5);

        // Reset during WRITE abandons the pending halfword store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b01;
        req_addr  = 32'h18;
        req_wdata = 32'h0000_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we = 1'b0;
        @(posedge clk);
        #1;
        check("in_write_state", {30'h0, dbg_state}, 32'd2);
        check("in_write_mem_we", {31'h0, mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_mem_we", {31'h0, mem_we}, 32'd0);
        check("rst_mid_state", {30'h0, dbg_state}, 32'd0);
        check("rst_mid_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_mid_mem_a", mem_a, 32'h0);
        check("rst_mid_mem_wd", mem_wd, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("mem6_untouched", mem[6], 32'hCAFE_F00D);
        check("rst_mid_rdata", resp_rdata, 32'h0);
        reset = 1'b1;

        // Normal operation resumes after reset.
        send(1'b0, 2'b01, 1'b0, 32'h1A, 32'h0, 32'h0000_CAFE, 1'b0, 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so a stuck handshake cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit reached");
    end

endmodule
